// File: rtl/lcd_frame_seq.sv
// LCD command/pixel sequencer: power-on init list, then per-frame window setup
// followed by H_RES*V_RES streamed RGB565 pixels, one word per clock.
module lcd_frame_seq #(
    parameter int H_RES     = 240,
    parameter int V_RES     = 320,
    parameter int RST_WAIT  = 120000,
    parameter int DELAY_CYC = 600000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [15:0] data,
    output logic [1:0]  lcd_ctrl,
    output logic        init_done,
    output logic        frame_done
);
    localparam longint unsigned TOTAL = longint'(H_RES) * longint'(V_RES);
    localparam int PW   = $clog2(TOTAL + 1);
    localparam int MAXD = (RST_WAIT > DELAY_CYC) ? RST_WAIT : DELAY_CYC;
    localparam int DW   = $clog2(MAXD + 1);
    localparam logic [15:0] HM1 = 16'(H_RES - 1);
    localparam logic [15:0] VM1 = 16'(V_RES - 1);
    localparam logic [1:0] CTRL_NONE = 2'b00;
    localparam logic [1:0] CTRL_CMD  = 2'b01;
    localparam logic [1:0] CTRL_DATA = 2'b10;

    typedef enum logic [2:0] {S_RST_WAIT, S_INIT, S_IDLE, S_WIN, S_PIX} state_t;

    state_t        state, state_d;
    logic [3:0]    step, step_d;
    logic          in_delay, in_delay_d;
    logic [DW-1:0] dcnt, dcnt_d;
    logic [PW-1:0] pcnt, pcnt_d;
    logic [15:0]   data_d;
    logic [1:0]    ctrl_d;
    logic          init_done_d, frame_done_d;

    function automatic logic [17:0] init_word(input logic [3:0] s);
        case (s)
            4'd0:    init_word = {CTRL_CMD,  16'h0001};
            4'd1:    init_word = {CTRL_CMD,  16'h0011};
            4'd2:    init_word = {CTRL_CMD,  16'h003A};
            4'd3:    init_word = {CTRL_DATA, 16'h0055};
            4'd4:    init_word = {CTRL_CMD,  16'h0036};
            4'd5:    init_word = {CTRL_DATA, 16'h0000};
            default: init_word = {CTRL_CMD,  16'h0029};
        endcase
    endfunction

    function automatic logic [17:0] win_word(input logic [3:0] s);
        case (s)
            4'd0:    win_word = {CTRL_CMD,  16'h002A};
            4'd3:    win_word = {CTRL_DATA, 8'h00, HM1[15:8]};
            4'd4:    win_word = {CTRL_DATA, 8'h00, HM1[7:0]};
            4'd5:    win_word = {CTRL_CMD,  16'h002B};
            4'd8:    win_word = {CTRL_DATA, 8'h00, VM1[15:8]};
            4'd9:    win_word = {CTRL_DATA, 8'h00, VM1[7:0]};
            4'd10:   win_word = {CTRL_CMD,  16'h002C};
            default: win_word = {CTRL_DATA, 16'h0000};
        endcase
    endfunction

    assign pix_ready = (state == S_PIX);

    always_comb begin
        state_d      = state;
        step_d       = step;
        in_delay_d   = in_delay;
        dcnt_d       = dcnt;
        pcnt_d       = pcnt;
        data_d       = data;
        ctrl_d       = CTRL_NONE;
        init_done_d  = init_done;
        frame_done_d = 1'b0;
        case (state)
            S_RST_WAIT: begin
                if (dcnt == DW'(RST_WAIT - 1)) begin
                    state_d    = S_INIT;
                    dcnt_d     = '0;
                    step_d     = '0;
                    in_delay_d = 1'b0;
                end else begin
                    dcnt_d = dcnt + DW'(1);
                end
            end
            S_INIT: begin
                if (in_delay) begin
                    if (dcnt == DW'(DELAY_CYC - 1)) begin
                        in_delay_d = 1'b0;
                        dcnt_d     = '0;
                        step_d     = step + 4'd1;
                    end else begin
                        dcnt_d = dcnt + DW'(1);
                    end
                end else begin
                    {ctrl_d, data_d} = init_word(step);
                    step_d = step + 4'd1;
                    // 0x01 and 0x11 are followed by a settle delay; step advances when it ends
                    if (step == 4'd0 || step == 4'd1) begin
                        in_delay_d = 1'b1;
                        dcnt_d     = '0;
                        step_d     = step;
                    end
                    if (step == 4'd6) begin
                        state_d = S_IDLE;
                        step_d  = '0;
                    end
                end
            end
            S_IDLE: begin
                init_done_d = 1'b1;
                if (frame_start) begin
                    state_d = S_WIN;
                    step_d  = '0;
                    pcnt_d  = '0;
                end
            end
            S_WIN: begin
                {ctrl_d, data_d} = win_word(step);
                if (step == 4'd10) begin
                    state_d = S_PIX;
                    step_d  = '0;
                end else begin
                    step_d = step + 4'd1;
                end
            end
            S_PIX: begin
                if (pix_valid) begin
                    data_d = pix_data;
                    ctrl_d = CTRL_DATA;
                    pcnt_d = pcnt + PW'(1);
                    if (pcnt == PW'(TOTAL - 1)) begin
                        state_d      = S_IDLE;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: state_d = S_RST_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_RST_WAIT;
            step       <= '0;
            in_delay   <= 1'b0;
            dcnt       <= '0;
            pcnt       <= '0;
            data       <= 16'h0000;
            lcd_ctrl   <= CTRL_NONE;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            step       <= step_d;
            in_delay   <= in_delay_d;
            dcnt       <= dcnt_d;
            pcnt       <= pcnt_d;
            data       <= data_d;
            lcd_ctrl   <= ctrl_d;
            init_done  <= init_done_d;
            frame_done <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_lcd_frame_seq.sv
// Bench for lcd_frame_seq: two instances (4x2 and 300x1) checked cycle by cycle
// against expected word streams built from the init/window/pixel rules.
module tb_lcd_frame_seq;
    localparam int RW = 4;
    localparam int DC = 8;
    localparam int HR [2] = '{4, 300};
    localparam int VR [2] = '{2, 1};
    localparam logic [1:0] C_CMD = 2'b01;
    localparam logic [1:0] C_DAT = 2'b10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fs  [2];
    logic [15:0] pd  [2];
    logic        pv  [2];
    logic        pr  [2];
    logic [15:0] dout[2];
    logic [1:0]  ctl [2];
    logic        idn [2];
    logic        fdn [2];
    logic [15:0] last_d [2];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lcd_frame_seq #(.H_RES(4), .V_RES(2), .RST_WAIT(RW), .DELAY_CYC(DC)) u_a (
        .clk(clk), .reset(reset), .frame_start(fs[0]), .pix_data(pd[0]), .pix_valid(pv[0]),
        .pix_ready(pr[0]), .data(dout[0]), .lcd_ctrl(ctl[0]), .init_done(idn[0]), .frame_done(fdn[0]));

    lcd_frame_seq #(.H_RES(300), .V_RES(1), .RST_WAIT(RW), .DELAY_CYC(DC)) u_b (
        .clk(clk), .reset(reset), .frame_start(fs[1]), .pix_data(pd[1]), .pix_valid(pv[1]),
        .pix_ready(pr[1]), .data(dout[1]), .lcd_ctrl(ctl[1]), .init_done(idn[1]), .frame_done(fdn[1]));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        for (int u = 0; u < 2; u++) begin
            fs[u] = 1'b0; pv[u] = 1'b0; pd[u] = 16'h0;
        end
        tick; tick;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (dout[u] !== 16'h0 || ctl[u] !== 2'b00 || idn[u] !== 1'b0 || fdn[u] !== 1'b0 || pr[u] !== 1'b0) begin
                failures++;
                $display("FAIL reset u%0d: data=%h ctrl=%b init_done=%b frame_done=%b pix_ready=%b, want all zero",
                         u, dout[u], ctl[u], idn[u], fdn[u], pr[u]);
            end
            last_d[u] = 16'h0;
        end
    endtask

    // Expected power-on stream, one entry per cycle after reset release
    task automatic test_init(input bit drop_fs);
        logic [17:0] q[$];
        logic [1:0]  ec;
        logic [15:0] ed;
        for (int i = 0; i < RW; i++) q.push_back(18'h0);
        q.push_back({C_CMD, 16'h0001});
        for (int i = 0; i < DC; i++) q.push_back(18'h0);
        q.push_back({C_CMD, 16'h0011});
        for (int i = 0; i < DC; i++) q.push_back(18'h0);
        q.push_back({C_CMD, 16'h003A});
        q.push_back({C_DAT, 16'h0055});
        q.push_back({C_CMD, 16'h0036});
        q.push_back({C_DAT, 16'h0000});
        q.push_back({C_CMD, 16'h0029});
        reset = 1'b1;
        for (int i = 0; i < q.size(); i++) begin
            for (int u = 0; u < 2; u++) fs[u] = drop_fs ? 1'($urandom_range(0, 1)) : 1'b0;
            tick;
            for (int u = 0; u < 2; u++) begin
                ec = q[i][17:16];
                ed = (ec == 2'b00) ? last_d[u] : q[i][15:0];
                checks++;
                if (ctl[u] !== ec || dout[u] !== ed || idn[u] !== 1'b0 || fdn[u] !== 1'b0 || pr[u] !== 1'b0) begin
                    failures++;
                    $display("FAIL init u%0d cycle %0d: ctrl=%b data=%h init_done=%b frame_done=%b pix_ready=%b, want ctrl=%b data=%h 0 0 0",
                             u, i, ctl[u], dout[u], idn[u], fdn[u], pr[u], ec, ed);
                end
                last_d[u] = ed;
            end
        end
        for (int u = 0; u < 2; u++) fs[u] = 1'b0;
        tick;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (idn[u] !== 1'b1 || ctl[u] !== 2'b00 || dout[u] !== last_d[u]) begin
                failures++;
                $display("FAIL init_done u%0d: init_done=%b ctrl=%b data=%h, want 1 00 %h",
                         u, idn[u], ctl[u], dout[u], last_d[u]);
            end
        end
    endtask

    // mode 0: valid held high, pixels 0x1000+n; mode 1: valid 1,0,0 repeating; mode 2: random
    task automatic run_frame(input int u, input int mode, input int abort_after, input bit fs_on_last);
        int total;
        int acc;
        int cyc;
        logic [15:0] hm, vm;
        logic [17:0] w[11];
        logic [1:0]  ec;
        logic [15:0] ed;
        logic        efd;
        total = HR[u] * VR[u];
        hm = 16'(HR[u] - 1);
        vm = 16'(VR[u] - 1);
        w = '{{C_CMD, 16'h002A}, {C_DAT, 16'h0}, {C_DAT, 16'h0},
              {C_DAT, 8'h0, hm[15:8]}, {C_DAT, 8'h0, hm[7:0]},
              {C_CMD, 16'h002B}, {C_DAT, 16'h0}, {C_DAT, 16'h0},
              {C_DAT, 8'h0, vm[15:8]}, {C_DAT, 8'h0, vm[7:0]},
              {C_CMD, 16'h002C}};
        fs[u] = 1'b1;
        tick;
        fs[u] = 1'b0;
        checks++;
        if (ctl[u] !== 2'b00 || dout[u] !== last_d[u] || pr[u] !== 1'b0) begin
            failures++;
            $display("FAIL start u%0d: ctrl=%b data=%h pix_ready=%b, want 00 %h 0", u, ctl[u], dout[u], pr[u], last_d[u]);
        end
        for (int i = 0; i < 11; i++) begin
            tick;
            checks++;
            if (ctl[u] !== w[i][17:16] || dout[u] !== w[i][15:0] || fdn[u] !== 1'b0 || pr[u] !== (i == 10)) begin
                failures++;
                $display("FAIL window u%0d word %0d: ctrl=%b data=%h frame_done=%b pix_ready=%b, want %b %h 0 %0d",
                         u, i, ctl[u], dout[u], fdn[u], pr[u], w[i][17:16], w[i][15:0], (i == 10));
            end
            last_d[u] = w[i][15:0];
        end
        acc = 0;
        cyc = 0;
        while (acc < total && cyc < total * 4 + 20) begin
            checks++;
            if (pr[u] !== 1'b1) begin
                failures++;
                $display("FAIL pix_ready u%0d after %0d pixels: got %b want 1", u, acc, pr[u]);
            end
            case (mode)
                0:       pv[u] = 1'b1;
                1:       pv[u] = (cyc % 3 == 0);
                default: pv[u] = 1'($urandom_range(0, 1));
            endcase
            pd[u] = (mode == 0) ? 16'(16'h1000 + acc) : 16'($urandom);
            fs[u] = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (fs_on_last && pv[u] && acc == total - 1) fs[u] = 1'b1;
            tick;
            cyc++;
            if (pv[u]) begin
                acc++;
                ec = C_DAT; ed = pd[u]; efd = (acc == total);
            end else begin
                ec = 2'b00; ed = last_d[u]; efd = 1'b0;
            end
            checks++;
            if (ctl[u] !== ec || dout[u] !== ed || fdn[u] !== efd) begin
                failures++;
                $display("FAIL pixel u%0d cycle %0d: ctrl=%b data=%h frame_done=%b, want %b %h %b",
                         u, cyc, ctl[u], dout[u], fdn[u], ec, ed, efd);
            end
            last_d[u] = ed;
            if (abort_after > 0 && acc == abort_after) begin
                pv[u] = 1'b0; fs[u] = 1'b0;
                return;
            end
        end
        pv[u] = 1'b0;
        fs[u] = 1'b0;
        checks++;
        if (acc != total) begin
            failures++;
            $display("FAIL frame_len u%0d: accepted %0d pixels in budget, want %0d", u, acc, total);
        end
        checks++;
        if (pr[u] !== 1'b0) begin
            failures++;
            $display("FAIL ready_after u%0d: pix_ready=%b want 0", u, pr[u]);
        end
    endtask

    task automatic test_frame;
        run_frame(0, 0, 0, 1'b0);
    endtask

    task automatic test_backpressure;
        run_frame(0, 1, 0, 1'b1);
    endtask

    task automatic test_back_to_back;
        run_frame(0, 2, 0, 1'b1);
        run_frame(0, 0, 0, 1'b0);
    endtask

    task automatic test_mid_reset;
        run_frame(0, 0, 3, 1'b0);
        reset = 1'b0;
        tick;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (dout[u] !== 16'h0 || ctl[u] !== 2'b00 || idn[u] !== 1'b0 || fdn[u] !== 1'b0 || pr[u] !== 1'b0) begin
                failures++;
                $display("FAIL mid_reset u%0d: data=%h ctrl=%b init_done=%b frame_done=%b pix_ready=%b, want all zero",
                         u, dout[u], ctl[u], idn[u], fdn[u], pr[u]);
            end
            last_d[u] = 16'h0;
        end
        test_init(1'b1);
    endtask

    task automatic test_wide_line;
        run_frame(1, 2, 0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_init(1'b1);
        test_frame;
        test_backpressure;
        test_back_to_back;
        test_mid_reset;
        test_wide_line;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
